// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream beat channel between the packet generator (master) and its sink.
// Carries payload, valid/ready handshake and end-of-packet marker.
interface axis_pkt_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits (pkt_len+1) beats per start request and counts packets.
// Optional macro AXIS_PKT_GEN_LFSR_EN switches the payload from incrementing to LFSR.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  m_aclk,
  input  logic                  m_areset_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [DATA_WIDTH-1:0] seed,
  axis_pkt_gen_if.master        m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_lat;
  logic [LEN_WIDTH-1:0] beat_idx;

  function automatic logic [DATA_WIDTH-1:0] next_payload(input logic [DATA_WIDTH-1:0] d);
`ifdef AXIS_PKT_GEN_LFSR_EN
    next_payload = {d[DATA_WIDTH-2:0],
                    d[DATA_WIDTH-1] ^ d[DATA_WIDTH-3] ^ d[DATA_WIDTH-4] ^ d[DATA_WIDTH-5]};
`else
    next_payload = d + DATA_WIDTH'(1);
`endif
  endfunction

  // An all-zero LFSR state would never advance, so zero seeds start at one.
  function automatic logic [DATA_WIDTH-1:0] first_payload(input logic [DATA_WIDTH-1:0] s);
`ifdef AXIS_PKT_GEN_LFSR_EN
    first_payload = (s == '0) ? DATA_WIDTH'(1) : s;
`else
    first_payload = s;
`endif
  endfunction

  // Packet FSM with all stream and status outputs registered.
  always_ff @(posedge m_aclk or negedge m_areset_n) begin
    if (!m_areset_n) begin
      state          <= IDLE;
      len_lat        <= '0;
      beat_idx       <= '0;
      m_axis.m_data  <= '0;
      m_axis.m_valid <= 1'b0;
      m_axis.m_last  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pkt_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state          <= SEND;
            len_lat        <= pkt_len;
            beat_idx       <= '0;
            m_axis.m_data  <= first_payload(seed);
            m_axis.m_valid <= 1'b1;
            m_axis.m_last  <= (pkt_len == '0);
            busy           <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          done <= 1'b0;
          if (m_axis.m_valid && m_axis.m_ready) begin
            if (m_axis.m_last) begin
              state          <= IDLE;
              m_axis.m_valid <= 1'b0;
              m_axis.m_last  <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
              pkt_count      <= pkt_count + CNT_WIDTH'(1);
            end else begin
              beat_idx      <= beat_idx + LEN_WIDTH'(1);
              m_axis.m_data <= next_payload(m_axis.m_data);
              m_axis.m_last <= ((beat_idx + LEN_WIDTH'(1)) == len_lat);
            end
          end else begin
            state <= SEND;
          end
        end
        default: begin
          state          <= IDLE;
          m_axis.m_valid <= 1'b0;
          m_axis.m_last  <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: constant vector table, hand sequences and
// randomized traffic compared against a queue-based packet model.
module tb_axis_pkt_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  pkt_len;
  logic [7:0]  seed;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  axis_pkt_gen_if #(.DATA_WIDTH(8)) axis ();

  axis_pkt_gen #(.DATA_WIDTH(8), .LEN_WIDTH(4), .CNT_WIDTH(16)) dut (
    .m_aclk     (clk),
    .m_areset_n (rst_n),
    .start      (start),
    .pkt_len    (pkt_len),
    .seed       (seed),
    .m_axis     (axis.master),
    .busy       (busy),
    .done       (done),
    .pkt_count  (pkt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a packet is the list of its remaining beats.
  logic [7:0]  mq[$];
  logic        m_busy;
  logic        m_done;
  logic [15:0] m_count;

  function automatic logic [7:0] pay_next(input logic [7:0] d);
`ifdef AXIS_PKT_GEN_LFSR_EN
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
`else
    return 8'(d + 8'd1);
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_count = 16'd0;
  endtask

  task automatic model_step(input logic s, input logic [3:0] l, input logic [7:0] sd,
                            input logic r);
    logic [7:0] d;
    m_done = 1'b0;
    if (m_busy) begin
      if (r) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_busy  = 1'b0;
          m_done  = 1'b1;
          m_count = m_count + 16'd1;
        end
      end
    end else if (s) begin
      d = sd;
`ifdef AXIS_PKT_GEN_LFSR_EN
      if (d == 8'd0) d = 8'd1;
`endif
      for (int i = 0; i <= int'(l); i++) begin
        mq.push_back(d);
        d = pay_next(d);
      end
      m_busy = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("valid", 32'(axis.m_valid), 32'(m_busy));
    chk("last", 32'(axis.m_last), 32'(m_busy && mq.size() == 1));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("count", 32'(pkt_count), 32'(m_count));
    if (m_busy) chk("data", 32'(axis.m_data), 32'(mq[0]));
  endtask

  // Inputs change just after the falling edge; outputs are checked at the next falling edge.
  task automatic cycle(input logic s, input logic [3:0] l, input logic [7:0] sd,
                       input logic r);
    start       = s;
    pkt_len     = l;
    seed        = sd;
    axis.m_ready = r;
    @(posedge clk);
    model_step(s, l, sd, r);
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic       s;
    logic [3:0] l;
    logic [7:0] sd;
    logic       r;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_done;
    logic [15:0] e_count;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] cnt_before;
    logic [7:0]  exp4 [4];

    rst_n        = 1'b0;
    start        = 1'b0;
    pkt_len      = 4'd0;
    seed         = 8'd0;
    axis.m_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(axis.m_valid), 32'd0);
    chk("rst_last", 32'(axis.m_last), 32'd0);
    chk("rst_data", 32'(axis.m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef AXIS_PKT_GEN_LFSR_EN
    tbl = '{
      '{1'b1, 4'd4, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 16'd0},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 16'd0},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 16'd0},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 16'd0},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 16'd0},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd1},
      '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 16'd1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd2},
      '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2}
    };
`else
    tbl = '{
      '{1'b1, 4'd3, 8'h10, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 16'd0},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 16'd0},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 16'd0},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h13, 1'b1, 1'b0, 16'd0},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1},
      '{1'b1, 4'd3, 8'h10, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 16'd1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 16'd1},
      '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 16'd1},
      '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 16'd1},
      '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 16'd1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 16'd1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h13, 1'b1, 1'b0, 16'd1},
      '{1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd2},
      '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2}
    };
`endif
    foreach (tbl[i]) begin
      cycle(tbl[i].s, tbl[i].l, tbl[i].sd, tbl[i].r);
      chk("tbl_valid", 32'(axis.m_valid), 32'(tbl[i].e_valid));
      chk("tbl_last", 32'(axis.m_last), 32'(tbl[i].e_last));
      chk("tbl_done", 32'(done), 32'(tbl[i].e_done));
      chk("tbl_count", 32'(pkt_count), 32'(tbl[i].e_count));
      if (tbl[i].e_valid) chk("tbl_data", 32'(axis.m_data), 32'(tbl[i].e_data));
    end

    // Single-beat packet.
    cnt_before = m_count;
    cycle(1'b1, 4'd0, 8'hA5, 1'b1);
    chk("len0_data", 32'(axis.m_data), 32'hA5);
    chk("len0_last", 32'(axis.m_last), 32'd1);
    cycle(1'b0, 4'd0, 8'h00, 1'b1);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_count", 32'(pkt_count), 32'(cnt_before + 16'd1));

    // Payload wrap, with a stray start mid-packet that must be ignored.
    cycle(1'b0, 4'd0, 8'h00, 1'b0);
    cnt_before = m_count;
    exp4 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    cycle(1'b1, 4'd3, 8'hFE, 1'b1);
    for (int i = 1; i < 4; i++) begin
`ifndef AXIS_PKT_GEN_LFSR_EN
      chk("wrap_data", 32'(axis.m_data), 32'(exp4[i-1]));
`endif
      cycle(i == 2, 4'd7, 8'h55, 1'b1);
    end
    cycle(1'b0, 4'd0, 8'h00, 1'b1);
    cycle(1'b0, 4'd0, 8'h00, 1'b1);
    chk("ignore_start_count", 32'(pkt_count), 32'(cnt_before + 16'd1));

    // Asynchronous reset in the middle of a packet.
    cycle(1'b1, 4'd3, 8'h40, 1'b1);
    cycle(1'b0, 4'd0, 8'h00, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(axis.m_valid), 32'd0);
    chk("arst_last", 32'(axis.m_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(pkt_count), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 4'd1, 8'h20, 1'b1);
    chk("post_rst_d0", 32'(axis.m_data), 32'h20);
    cycle(1'b0, 4'd0, 8'h00, 1'b1);
`ifndef AXIS_PKT_GEN_LFSR_EN
    chk("post_rst_d1", 32'(axis.m_data), 32'h21);
`endif
    chk("post_rst_last", 32'(axis.m_last), 32'd1);
    cycle(1'b0, 4'd0, 8'h00, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
